bus_requester: RTL and testbench
================================

BUS_REQUESTER -- requirements
Module: bus_requester

Interface
REQ-001 SHALL have parameter MY_ID, default 2'b00, the grant code this agent answers to (00/01/10).
REQ-002 SHALL have parameter DATA_W, default 8, the bus data width.
REQ-003 SHALL have parameter MAX_BURST, default 4, the maximum beats per tenure (1..8).
REQ-004 SHALL have parameter GRANT_TIMEOUT, default 15, the maximum cycles REQ waits for grant (1..255).
REQ-005 SHALL use one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 wr_valid  input  1  local word offered.
REQ-009 wr_data  input  DATA_W  local word.
REQ-010 wr_ready  output  1  buffer can accept; high when count<4.
REQ-011 req  output  1  bus request to the arbiter (registered).
REQ-012 grant  input  2  arbiter grant code; 2'b11 = none.
REQ-013 bus_valid  output  1  beat on bus this cycle.
REQ-014 bus_data  output  DATA_W  beat data (buffer head).
REQ-015 bus_last  output  1  final beat of the tenure.
REQ-016 timeout  output  1  one-cycle pulse: grant wait expired.
REQ-017 preempt  output  1  one-cycle pulse: grant lost mid-burst.

Function
REQ-018 SHALL buffer local words in a 4-entry FIFO; push when wr_valid&&wr_ready; pop only on bus_valid.
REQ-019 Simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-020 SHALL implement FSM IDLE, REQ, XFER, RELEASE.
REQ-021 IDLE: req=0; count!=0 -> REQ next cycle.
REQ-022 REQ: req=1 and wait_cnt increments each cycle; grant==MY_ID -> XFER, beat_cnt=0; otherwise wait_cnt==GRANT_TIMEOUT-1 -> RELEASE with timeout pulse; grant takes priority over timeout in the same cycle.
REQ-023 XFER: req=1; bus_valid = (grant==MY_ID) combinationally; each valid beat pops one word and increments beat_cnt.
REQ-024 bus_last SHALL be high with bus_valid when beat_cnt==MAX_BURST-1 or count==1; the cycle after, XFER -> RELEASE.
REQ-025 grant!=MY_ID in XFER SHALL force bus_valid=0, no pop, preempt pulse, XFER -> RELEASE; unsent words stay buffered.
REQ-026 RELEASE: req=0 for exactly one cycle, then IDLE; words remaining trigger a new REQ from IDLE.
REQ-027 bus_data SHALL equal the FIFO head whenever bus_valid=1, and 0 otherwise.
REQ-028 Pushes SHALL continue in every state; a push during XFER may extend the burst up to MAX_BURST.

Reset
REQ-029 rst SHALL asynchronously force state IDLE, count 0, pointers 0, wait_cnt 0, beat_cnt 0.
REQ-030 During and after reset: req=0, bus_valid=0, bus_last=0, timeout=0, preempt=0, wr_ready=1; bus_data=0.
REQ-031 Reset mid-burst SHALL discard all buffered words; no beat SHALL appear until a new push and grant.

Structure
REQ-032 The shared package bus_arb_pkg SHALL hold grant codes GNT_A=2'b00, GNT_B=2'b01, GNT_C=2'b10, GNT_NONE=2'b11 and the FSM state type.
REQ-033 The FIFO SHALL be the sub-module bus_req_fifo (depth 4, DATA_W wide, count output); the FSM and counters stay in bus_requester.

Verification
REQ-034 Push 3 words A1,A2,A3 with MY_ID=01; grant=01 two cycles after req -> beats A1,A2,A3 on consecutive cycles, bus_last with A3, req low one cycle, then IDLE.
REQ-035 Push 6 words, MAX_BURST=4, grant held -> first tenure 4 beats (last on 4th), RELEASE, re-request, second tenure 2 beats.
REQ-036 Push 1 word, grant held at 2'b11 -> timeout pulse on cycle 15 of REQ, req drops one cycle, then re-asserts; the word is still buffered.
REQ-037 Grant removed after beat 2 of 4 -> preempt pulse, no pop that cycle, words 3 and 4 are sent first in the next tenure.
REQ-038 Push 4 words (wr_ready=0), then assert rst mid-XFER -> all outputs at reset values immediately, count 0, wr_ready=1.
REQ-039 Push and pop in the same XFER cycle at count 2 -> count stays 2, the pushed word follows the existing words.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - grant codes, requester FSM states and buffer sizing
package bus_arb_pkg;

  localparam logic [1:0] GNT_A    = 2'b00;
  localparam logic [1:0] GNT_B    = 2'b01;
  localparam logic [1:0] GNT_C    = 2'b10;
  localparam logic [1:0] GNT_NONE = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_REQ     = 2'd1;
  localparam state_t ST_XFER    = 2'd2;
  localparam state_t ST_RELEASE = 2'd3;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 3;

endpackage

// File: rtl/bus_req_fifo.sv
// rtl/bus_req_fifo.sv - 4-entry word buffer feeding the bus, head always visible
module bus_req_fifo
  import bus_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + 2'd1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale contents are never observed once count is 0.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/bus_requester.sv
// rtl/bus_requester.sv - buffers local words and bursts them onto a shared arbitrated bus
module bus_requester
  import bus_arb_pkg::*;
#(
  parameter logic [1:0] MY_ID         = GNT_A,
  parameter int         DATA_W        = 8,
  parameter int         MAX_BURST     = 4,
  parameter int         GRANT_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              req,
  input  logic [1:0]        grant,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_last,
  output logic              timeout,
  output logic              preempt
);

  localparam logic [2:0] LAST_BEAT = 3'(MAX_BURST - 1);
  localparam logic [7:0] WAIT_LAST = 8'(GRANT_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        wait_q, wait_d;
  logic [2:0]        beat_q, beat_d;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] head;
  logic              push;
  logic              granted;

  assign granted   = (grant == MY_ID);
  assign wr_ready  = (count < CNT_W'(FIFO_DEPTH));
  assign push      = wr_valid && wr_ready;
  assign req       = (state_q == ST_REQ) || (state_q == ST_XFER);
  assign bus_valid = (state_q == ST_XFER) && granted;
  // The burst ends on the beat budget or when the buffer is about to drain.
  assign bus_last  = bus_valid && ((beat_q == LAST_BEAT) || (count == CNT_W'(1)));
  assign bus_data  = bus_valid ? head : '0;
  assign timeout   = (state_q == ST_REQ) && !granted && (wait_q == WAIT_LAST);
  assign preempt   = (state_q == ST_XFER) && !granted;

  bus_req_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wr_data),
    .pop_i   (bus_valid),
    .head_o  (head),
    .count_o (count)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    beat_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (count != '0) state_d = ST_REQ;
      end
      ST_REQ: begin
        wait_d = wait_q + 8'd1;
        if (granted)      state_d = ST_XFER;
        else if (timeout) state_d = ST_RELEASE;
      end
      ST_XFER: begin
        beat_d = beat_q + {2'b00, bus_valid};
        if (!bus_valid || bus_last) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_bus_requester.sv
// tb/tb_bus_requester.sv - directed cycle-by-cycle checks of bus_requester
module tb_bus_requester;
  import bus_arb_pkg::*;

  typedef struct packed {
    logic        wv;
    logic [7:0]  wd;
    logic [1:0]  g;
    logic [13:0] exp;
  } vec_t;

  // {wr_ready, req, bus_valid, bus_last, timeout, preempt}
  localparam logic [5:0] C_IDLE  = 6'b100000;
  localparam logic [5:0] C_REQ   = 6'b110000;
  localparam logic [5:0] C_BEAT  = 6'b111000;
  localparam logic [5:0] C_LAST  = 6'b111100;
  localparam logic [5:0] C_TO    = 6'b110010;
  localparam logic [5:0] C_PE    = 6'b110001;
  localparam logic [5:0] C_FREQ  = 6'b010000;
  localparam logic [5:0] C_FBEAT = 6'b011000;
  localparam logic [1:0] ME = GNT_B;
  localparam logic [1:0] NO = GNT_NONE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [1:0] grant = GNT_NONE;
  logic       wr_ready, req, bus_valid, bus_last, timeout, preempt;
  logic [7:0] bus_data;
  logic [13:0] obs;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_requester #(
    .MY_ID(GNT_B), .DATA_W(8), .MAX_BURST(4), .GRANT_TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .req(req), .grant(grant), .bus_valid(bus_valid), .bus_data(bus_data),
    .bus_last(bus_last), .timeout(timeout), .preempt(preempt)
  );

  assign obs = {wr_ready, req, bus_valid, bus_last, timeout, preempt, bus_data};

  function automatic vec_t mk(input logic wv, input logic [7:0] wd, input logic [1:0] g,
                              input logic [5:0] ctl, input logic [7:0] bd);
    vec_t r;
    r.wv = wv; r.wd = wd; r.g = g; r.exp = {ctl, bd};
    return r;
  endfunction

  task automatic test_reset;
    wr_valid = 1'b1; wr_data = 8'hFF;
    @(negedge clk);
    checks++;
    if (obs !== {C_IDLE, 8'h00}) begin
      errors++;
      $display("FAIL reset_hold: got rdy/req/vld/last/to/pe=%b data=%h required %b data=00", obs[13:8], obs[7:0], C_IDLE);
    end
    @(posedge clk); #1;
    rst = 1'b0; wr_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== {C_IDLE, 8'h00}) begin
        errors++;
        $display("FAIL reset_after cycle %0d: got %b data=%h required %b data=00", i, obs[13:8], obs[7:0], C_IDLE);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic;
    vec_t v[$];
    v.push_back(mk(1, 8'hA1, NO, C_IDLE, 8'h00));
    v.push_back(mk(1, 8'hA2, NO, C_IDLE, 8'h00));
    v.push_back(mk(1, 8'hA3, NO, C_REQ,  8'h00));
    v.push_back(mk(0, 8'h00, NO, C_REQ,  8'h00));
    v.push_back(mk(0, 8'h00, ME, C_REQ,  8'h00));
    v.push_back(mk(0, 8'h00, ME, C_BEAT, 8'hA1));
    v.push_back(mk(0, 8'h00, ME, C_BEAT, 8'hA2));
    v.push_back(mk(0, 8'h00, ME, C_LAST, 8'hA3));
    v.push_back(mk(0, 8'h00, ME, C_IDLE, 8'h00));
    v.push_back(mk(0, 8'h00, ME, C_IDLE, 8'h00));
    v.push_back(mk(0, 8'h00, ME, C_IDLE, 8'h00));
    foreach (v[i]) begin
      wr_valid = v[i].wv; wr_data = v[i].wd; grant = v[i].g;
      @(negedge clk);
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL basic cycle %0d: got %b data=%h required %b data=%h", i, obs[13:8], obs[7:0], v[i].exp[13:8], v[i].exp[7:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_burst_split;
    vec_t v[$];
    v.push_back(mk(1, 8'h11, ME, C_IDLE, 8'h00));
    v.push_back(mk(1, 8'h12, ME, C_IDLE, 8'h00));
    v.push_back(mk(1, 8'h13, ME, C_REQ,  8'h00));
    v.push_back(mk(1, 8'h14, ME, C_BEAT, 8'h11));
    v.push_back(mk(1, 8'h15, ME, C_BEAT, 8'h12));
    v.push_back(mk(1, 8'h16, ME, C_BEAT, 8'h13));
    v.push_back(mk(0, 8'h00, ME, C_LAST, 8'h14));
    v.push_back(mk(0, 8'h00, ME, C_IDLE, 8'h00));
    v.push_back(mk(0, 8'h00, ME, C_IDLE, 8'h00));
    v.push_back(mk(0, 8'h00, ME, C_REQ,  8'h00));
    v.push_back(mk(0, 8'h00, ME, C_BEAT, 8'h15));
    v.push_back(mk(0, 8'h00, ME, C_LAST, 8'h16));
    v.push_back(mk(0, 8'h00, ME, C_IDLE, 8'h00));
    v.push_back(mk(0, 8'h00, ME, C_IDLE, 8'h00));
    v.push_back(mk(0, 8'h00, ME, C_IDLE, 8'h00));
    foreach (v[i]) begin
      wr_valid = v[i].wv; wr_data = v[i].wd; grant = v[i].g;
      @(negedge clk);
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL burst_split cycle %0d: got %b data=%h required %b data=%h", i, obs[13:8], obs[7:0], v[i].exp[13:8], v[i].exp[7:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout;
    vec_t v[$];
    v.push_back(mk(1, 8'h5A, NO, C_IDLE, 8'h00));
    v.push_back(mk(0, 8'h00, NO, C_IDLE, 8'h00));
    for (int k = 1; k <= 14; k++) v.push_back(mk(0, 8'h00, NO, C_REQ, 8'h00));
    v.push_back(mk(0, 8'h00, NO, C_TO,   8'h00));
    v.push_back(mk(0, 8'h00, NO, C_IDLE, 8'h00));
    v.push_back(mk(0, 8'h00, NO, C_IDLE, 8'h00));
    v.push_back(mk(0, 8'h00, NO, C_REQ,  8'h00));
    v.push_back(mk(0, 8'h00, ME, C_REQ,  8'h00));
    v.push_back(mk(0, 8'h00, ME, C_LAST, 8'h5A));
    v.push_back(mk(0, 8'h00, ME, C_IDLE, 8'h00));
    v.push_back(mk(0, 8'h00, ME, C_IDLE, 8'h00));
    foreach (v[i]) begin
      wr_valid = v[i].wv; wr_data = v[i].wd; grant = v[i].g;
      @(negedge clk);
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL timeout cycle %0d: got %b data=%h required %b data=%h", i, obs[13:8], obs[7:0], v[i].exp[13:8], v[i].exp[7:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_preempt;
    vec_t v[$];
    v.push_back(mk(1, 8'h31, NO, C_IDLE,  8'h00));
    v.push_back(mk(1, 8'h32, NO, C_IDLE,  8'h00));
    v.push_back(mk(1, 8'h33, NO, C_REQ,   8'h00));
    v.push_back(mk(1, 8'h34, NO, C_REQ,   8'h00));
    v.push_back(mk(0, 8'h00, ME, C_FREQ,  8'h00));
    v.push_back(mk(0, 8'h00, ME, C_FBEAT, 8'h31));
    v.push_back(mk(0, 8'h00, ME, C_BEAT,  8'h32));
    v.push_back(mk(0, 8'h00, NO, C_PE,    8'h00));
    v.push_back(mk(0, 8'h00, ME, C_IDLE,  8'h00));
    v.push_back(mk(0, 8'h00, ME, C_IDLE,  8'h00));
    v.push_back(mk(0, 8'h00, ME, C_REQ,   8'h00));
    v.push_back(mk(0, 8'h00, ME, C_BEAT,  8'h33));
    v.push_back(mk(0, 8'h00, ME, C_LAST,  8'h34));
    v.push_back(mk(0, 8'h00, ME, C_IDLE,  8'h00));
    v.push_back(mk(0, 8'h00, ME, C_IDLE,  8'h00));
    foreach (v[i]) begin
      wr_valid = v[i].wv; wr_data = v[i].wd; grant = v[i].g;
      @(negedge clk);
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL preempt cycle %0d: got %b data=%h required %b data=%h", i, obs[13:8], obs[7:0], v[i].exp[13:8], v[i].exp[7:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_xfer;
    vec_t v[$];
    for (int ph = 0; ph < 2; ph++) begin
      v.delete();
      if (ph == 0) begin
        v.push_back(mk(1, 8'h41, NO, C_IDLE,  8'h00));
        v.push_back(mk(1, 8'h42, NO, C_IDLE,  8'h00));
        v.push_back(mk(1, 8'h43, NO, C_REQ,   8'h00));
        v.push_back(mk(1, 8'h44, NO, C_REQ,   8'h00));
        v.push_back(mk(0, 8'h00, ME, C_FREQ,  8'h00));
        v.push_back(mk(0, 8'h00, ME, C_FBEAT, 8'h41));
      end else begin
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== {C_IDLE, 8'h00}) begin
          errors++;
          $display("FAIL reset_mid_immediate: got %b data=%h required %b data=00", obs[13:8], obs[7:0], C_IDLE);
        end
        @(negedge clk);
        checks++;
        if (obs !== {C_IDLE, 8'h00}) begin
          errors++;
          $display("FAIL reset_mid_held: got %b data=%h required %b data=00", obs[13:8], obs[7:0], C_IDLE);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        v.push_back(mk(0, 8'h00, ME, C_IDLE, 8'h00));
        v.push_back(mk(0, 8'h00, ME, C_IDLE, 8'h00));
        v.push_back(mk(1, 8'hA9, ME, C_IDLE, 8'h00));
        v.push_back(mk(0, 8'h00, ME, C_IDLE, 8'h00));
        v.push_back(mk(0, 8'h00, ME, C_REQ,  8'h00));
        v.push_back(mk(0, 8'h00, ME, C_LAST, 8'hA9));
        v.push_back(mk(0, 8'h00, ME, C_IDLE, 8'h00));
        v.push_back(mk(0, 8'h00, ME, C_IDLE, 8'h00));
      end
      foreach (v[i]) begin
        wr_valid = v[i].wv; wr_data = v[i].wd; grant = v[i].g;
        @(negedge clk);
        checks++;
        if (obs !== v[i].exp) begin
          errors++;
          $display("FAIL reset_mid phase %0d cycle %0d: got %b data=%h required %b data=%h", ph, i, obs[13:8], obs[7:0], v[i].exp[13:8], v[i].exp[7:0]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_push_pop_same_cycle;
    vec_t v[$];
    v.push_back(mk(1, 8'hE1, NO, C_IDLE, 8'h00));
    v.push_back(mk(1, 8'hE2, NO, C_IDLE, 8'h00));
    v.push_back(mk(0, 8'h00, NO, C_REQ,  8'h00));
    v.push_back(mk(0, 8'h00, ME, C_REQ,  8'h00));
    v.push_back(mk(1, 8'hE3, ME, C_BEAT, 8'hE1));
    v.push_back(mk(0, 8'h00, ME, C_BEAT, 8'hE2));
    v.push_back(mk(0, 8'h00, ME, C_LAST, 8'hE3));
    v.push_back(mk(0, 8'h00, ME, C_IDLE, 8'h00));
    v.push_back(mk(0, 8'h00, NO, C_IDLE, 8'h00));
    foreach (v[i]) begin
      wr_valid = v[i].wv; wr_data = v[i].wd; grant = v[i].g;
      @(negedge clk);
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL push_pop cycle %0d: got %b data=%h required %b data=%h", i, obs[13:8], obs[7:0], v[i].exp[13:8], v[i].exp[7:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_burst_split();
    test_timeout();
    test_preempt();
    test_reset_mid_xfer();
    test_push_pop_same_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
